// File: rtl/hud_card_addr.sv
// HUD card texture addressing: two-stage pixel-to-BRAM address pipeline with a
// per-player slot reveal sequencer that hides cards until their turn comes.
module hud_card_addr #(
  parameter int MEM_W         = 120,
  parameter int IMG_W         = 60,
  parameter int IMG_H         = 120,
  parameter int SLOTS         = 3,
  parameter int Y0            = 360,
  parameter int P1_X0         = 60,
  parameter int P2_X0         = 400,
  parameter int REVEAL_FRAMES = 30,
  parameter int ADDR_W        = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_start,
  input  logic [SLOTS-1:0]  p1_pattern,
  input  logic [SLOTS-1:0]  p2_pattern,
  input  logic              p1_reveal,
  input  logic              p2_reveal,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              is_active,
  output logic              player,
  output logic [2:0]        slot_idx,
  output logic              p1_busy,
  output logic              p2_busy
);

  localparam int REV_W = $clog2(SLOTS + 1);
  localparam int FRM_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam logic [REV_W-1:0] REV_MAX  = REV_W'(SLOTS);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(REVEAL_FRAMES - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           r_state  [2];
  logic [REV_W-1:0] r_rev    [2];
  logic [FRM_W-1:0] r_frm    [2];
  state_t           w_state_nx [2];
  logic [REV_W-1:0] w_rev_nx [2];
  logic [FRM_W-1:0] w_frm_nx [2];
  logic [1:0]       w_reveal;

  logic [SLOTS-1:0] r_pat1, r_pat2;

  logic [31:0] w_h, w_v, w_dx, w_slot, w_lx, w_ly;
  logic        w_in_v, w_in_p1, w_in_p2, w_sel_p2, w_visible, w_act, w_patbit;
  logic [REV_W-1:0] w_rev_cur;
  logic [7:0]  w_pat8;

  logic        r1_act, r1_player, r1_pat;
  logic [2:0]  r1_slot;
  logic [9:0]  r1_lx, r1_ly;
  logic [31:0] w_addr_full;

  assign w_reveal = {p2_reveal, p1_reveal};

  // Reveal sequencer next state; a reveal pulse overrides any frame advance.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_state_nx[p] = r_state[p];
      w_rev_nx[p]   = r_rev[p];
      w_frm_nx[p]   = r_frm[p];
      if (w_reveal[p]) begin
        w_state_nx[p] = ST_RUN;
        w_rev_nx[p]   = {REV_W{1'b0}};
        w_frm_nx[p]   = {FRM_W{1'b0}};
      end else if (r_state[p] == ST_RUN) begin
        if (frame_start) begin
          if (r_frm[p] == FRM_LAST) begin
            w_frm_nx[p] = {FRM_W{1'b0}};
            w_rev_nx[p] = r_rev[p] + {{(REV_W-1){1'b0}}, 1'b1};
          end else begin
            w_frm_nx[p] = r_frm[p] + {{(FRM_W-1){1'b0}}, 1'b1};
            w_rev_nx[p] = r_rev[p];
          end
        end else begin
          w_frm_nx[p] = r_frm[p];
          w_rev_nx[p] = r_rev[p];
        end
        if (w_rev_nx[p] == REV_MAX) begin
          w_state_nx[p] = ST_IDLE;
        end else begin
          w_state_nx[p] = ST_RUN;
        end
      end else begin
        w_state_nx[p] = ST_IDLE;
        w_rev_nx[p]   = REV_MAX;
        w_frm_nx[p]   = {FRM_W{1'b0}};
      end
    end
  end

  // Reveal sequencer state registers and frame-latched card patterns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        r_state[p] <= ST_IDLE;
        r_rev[p]   <= REV_MAX;
        r_frm[p]   <= {FRM_W{1'b0}};
      end
      r_pat1 <= {SLOTS{1'b0}};
      r_pat2 <= {SLOTS{1'b0}};
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_state[p] <= w_state_nx[p];
        r_rev[p]   <= w_rev_nx[p];
        r_frm[p]   <= w_frm_nx[p];
      end
      if (frame_start) begin
        r_pat1 <= p1_pattern;
        r_pat2 <= p2_pattern;
      end else begin
        r_pat1 <= r_pat1;
        r_pat2 <= r_pat2;
      end
    end
  end

  assign p1_busy = (r_state[0] == ST_RUN);
  assign p2_busy = (r_state[1] == ST_RUN);

  // Stage-1 decode; P1 takes priority should the two regions ever overlap.
  always_comb begin
    w_h       = 32'(h_cnt);
    w_v       = 32'(v_cnt);
    w_in_v    = (w_v >= 32'(Y0)) && (w_v < 32'(Y0 + IMG_H));
    w_in_p1   = w_in_v && (w_h >= 32'(P1_X0)) && (w_h < 32'(P1_X0 + SLOTS * IMG_W));
    w_in_p2   = w_in_v && (w_h >= 32'(P2_X0)) && (w_h < 32'(P2_X0 + SLOTS * IMG_W));
    w_sel_p2  = !w_in_p1;
    w_dx      = w_sel_p2 ? (w_h - 32'(P2_X0)) : (w_h - 32'(P1_X0));
    w_slot    = w_dx / 32'(IMG_W);
    w_lx      = w_dx % 32'(IMG_W);
    w_ly      = w_v - 32'(Y0);
    w_rev_cur = w_sel_p2 ? r_rev[1] : r_rev[0];
    w_pat8    = w_sel_p2 ? 8'(r_pat2) : 8'(r_pat1);
    w_visible = w_slot < 32'(w_rev_cur);
    w_act     = (w_in_p1 || w_in_p2) && w_visible;
    w_patbit  = w_pat8[w_slot[2:0]];
  end

  // Stage-1 pipeline registers; everything is zeroed for inactive pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_act    <= 1'b0;
      r1_player <= 1'b0;
      r1_slot   <= 3'd0;
      r1_pat    <= 1'b0;
      r1_lx     <= 10'd0;
      r1_ly     <= 10'd0;
    end else begin
      r1_act    <= w_act;
      r1_player <= w_act & w_sel_p2;
      r1_slot   <= w_act ? w_slot[2:0] : 3'd0;
      r1_pat    <= w_act & w_patbit;
      r1_lx     <= w_act ? w_lx[9:0] : 10'd0;
      r1_ly     <= w_act ? w_ly[9:0] : 10'd0;
    end
  end

  assign w_addr_full = 32'(r1_ly) * 32'(MEM_W) + (r1_pat ? 32'(IMG_W) : 32'd0) + 32'(r1_lx);

  // Stage-2 output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= {ADDR_W{1'b0}};
      is_active <= 1'b0;
      player    <= 1'b0;
      slot_idx  <= 3'd0;
    end else begin
      mem_addr  <= r1_act ? w_addr_full[ADDR_W-1:0] : {ADDR_W{1'b0}};
      is_active <= r1_act;
      player    <= r1_player;
      slot_idx  <= r1_slot;
    end
  end

endmodule

// File: tb/tb_hud_card_addr.sv
// Randomized bench for hud_card_addr against a frame-counting reference model.
module tb_hud_card_addr;

  localparam int MEM_W = 120, IMG_W = 60, IMG_H = 120, SLOTS = 3;
  localparam int Y0 = 360, P1_X0 = 60, P2_X0 = 400, RF = 2, ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        h_cnt = 10'd0, v_cnt = 10'd0;
  logic              frame_start = 1'b0;
  logic [SLOTS-1:0]  p1_pattern = 3'd0, p2_pattern = 3'd0;
  logic              p1_reveal = 1'b0, p2_reveal = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              is_active, player, p1_busy, p2_busy;
  logic [2:0]        slot_idx;

  hud_card_addr #(
    .MEM_W(MEM_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .SLOTS(SLOTS), .Y0(Y0),
    .P1_X0(P1_X0), .P2_X0(P2_X0), .REVEAL_FRAMES(RF), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .frame_start(frame_start), .p1_pattern(p1_pattern), .p2_pattern(p2_pattern),
    .p1_reveal(p1_reveal), .p2_reveal(p2_reveal), .mem_addr(mem_addr),
    .is_active(is_active), .player(player), .slot_idx(slot_idx),
    .p1_busy(p1_busy), .p2_busy(p2_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] addr;
    logic        act;
    logic        pl;
    logic [2:0]  slot;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cmp_en  = 1'b0;
  // Model: frames elapsed since the last reveal pulse (-1 = no sequence running).
  int   fs_m [2];
  logic [2:0] pat_m [2];
  exp_t pipe0, pipe1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int vis(input int p);
    return (fs_m[p] < 0) ? SLOTS : fs_m[p] / RF;
  endfunction

  function automatic exp_t calc(input int h, input int v, input logic [2:0] pa,
                                input logic [2:0] pb, input int va, input int vb);
    exp_t e;
    bit found;
    int x0, s;
    logic [2:0] pat;
    e = '0;
    found = 1'b0;
    if (v >= Y0 && v < Y0 + IMG_H) begin
      for (int p = 0; p < 2; p++) begin
        x0  = (p == 0) ? P1_X0 : P2_X0;
        pat = (p == 0) ? pa : pb;
        if (!found && h >= x0 && h < x0 + SLOTS * IMG_W) begin
          found = 1'b1;
          s = (h - x0) / IMG_W;
          if (s < ((p == 0) ? va : vb)) begin
            e.act  = 1'b1;
            e.pl   = p[0];
            e.slot = s[2:0];
            e.addr = 14'((v - Y0) * MEM_W + (pat[s] ? IMG_W : 0) + (h - x0) % IMG_W);
          end
        end
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    fs_m[0] = -1; fs_m[1] = -1;
    pat_m[0] = 3'd0; pat_m[1] = 3'd0;
    pipe0 = '0; pipe1 = '0;
  endtask

  // Reference model advances on each rising edge while out of reset.
  always @(posedge clk) begin : mdl
    exp_t e;
    bit   r;
    if (rst_n) begin
      e = calc(int'(h_cnt), int'(v_cnt), pat_m[0], pat_m[1], vis(0), vis(1));
      pipe1 = pipe0;
      pipe0 = e;
      for (int p = 0; p < 2; p++) begin
        r = (p == 0) ? p1_reveal : p2_reveal;
        if (r) fs_m[p] = 0;
        else if (fs_m[p] >= 0 && frame_start) begin
          fs_m[p]++;
          if (fs_m[p] >= SLOTS * RF) fs_m[p] = -1;
        end
      end
      if (frame_start) begin
        pat_m[0] = p1_pattern;
        pat_m[1] = p2_pattern;
      end
    end
  end

  // Compare process: DUT outputs against the model shortly after every edge.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("mem_addr", int'(mem_addr), int'(pipe1.addr));
      check("is_active", int'(is_active), int'(pipe1.act));
      check("player", int'(player), int'(pipe1.pl));
      check("slot_idx", int'(slot_idx), int'(pipe1.slot));
      check("p1_busy", int'(p1_busy), (fs_m[0] >= 0) ? 1 : 0);
      check("p2_busy", int'(p2_busy), (fs_m[1] >= 0) ? 1 : 0);
    end
  end

  task automatic drive(input int h, input int v, input bit fs, input bit r1, input bit r2);
    h_cnt = 10'(h); v_cnt = 10'(v);
    frame_start = fs; p1_reveal = r1; p2_reveal = r2;
    @(negedge clk);
  endtask

  task automatic frame();
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s < SLOTS; s++) begin
      drive(P1_X0 + 30 + 60 * s, 400, 1'b0, 1'b0, 1'b0);
      drive(P2_X0 + 30 + 60 * s, 401, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    exp_t e;
    model_reset();
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Model pins from hand-computed values.
    e = calc(60, 360, 3'b010, 3'b000, 3, 3);
    check("pin_a_addr", int'(e.addr), 0);
    check("pin_a_act", int'(e.act), 1);
    e = calc(125, 361, 3'b010, 3'b000, 3, 3);
    check("pin_b_addr", int'(e.addr), 185);
    check("pin_b_slot", int'(e.slot), 1);
    e = calc(579, 479, 3'b000, 3'b100, 3, 3);
    check("pin_c_addr", int'(e.addr), 14399);
    check("pin_c_pl", int'(e.pl), 1);
    e = calc(240, 400, 3'b000, 3'b100, 3, 3);
    check("pin_d_act", int'(e.act), 0);

    // Known-answer pixels straight off the DUT.
    p1_pattern = 3'b010; p2_pattern = 3'b100;
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    drive(60, 360, 1'b0, 1'b0, 1'b0);
    drive(125, 361, 1'b0, 1'b0, 1'b0);
    check("kat_addr0", int'(mem_addr), 0);
    check("kat_act0", int'(is_active), 1);
    drive(579, 479, 1'b0, 1'b0, 1'b0);
    check("kat_addr185", int'(mem_addr), 185);
    check("kat_slot1", int'(slot_idx), 1);
    drive(240, 400, 1'b0, 1'b0, 1'b0);
    check("kat_addr14399", int'(mem_addr), 14399);
    check("kat_player1", int'(player), 1);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    check("kat_outside", int'(is_active), 0);

    // Pattern change mid-frame stays invisible until the next frame_start.
    p1_pattern = 3'b101;
    frame();
    frame();

    // Reveal sequence on P1 only.
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    check("rev_busy", int'(p1_busy), 1);
    check("rev_vis0", vis(0), 0);
    frame(); frame();
    check("rev_vis1", vis(0), 1);
    repeat (4) frame();
    check("rev_done", int'(p1_busy), 0);
    check("rev_p2_idle", int'(p2_busy), 0);
    frame();

    // Reveal coincident with frame_start, then reset mid-run.
    drive(0, 0, 1'b1, 1'b1, 1'b0);
    check("coinc_vis0", vis(0), 0);
    check("coinc_busy", int'(p1_busy), 1);
    repeat (3) frame();
    rst_n = 1'b0;
    model_reset();
    drive(100, 400, 1'b0, 1'b0, 1'b0);
    check("rst_busy", int'(p1_busy), 0);
    check("rst_active", int'(is_active), 0);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    frame(); frame();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15, 0) == 0) p1_pattern = 3'($urandom);
      if ($urandom_range(15, 0) == 0) p2_pattern = 3'($urandom);
      if (i == 1500) begin
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
      end
      drive($urandom_range(700, 0), $urandom_range(500, 340),
            ($urandom_range(7, 0) == 0), ($urandom_range(63, 0) == 0),
            ($urandom_range(63, 0) == 0));
    end
    repeat (3) drive(0, 0, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
